// File: rtl/accel_wrap_pkg.sv
// Shared definitions for the AHB FIFO accelerator wrapper: register map,
// STATUS bit positions, engine state encoding and the address decoder.
package accel_wrap_pkg;

  localparam logic [11:0] PUSH_BASE     = 12'h000;
  localparam logic [11:0] POP_BASE      = 12'h400;
  localparam logic [11:0] STATUS_OFFSET = 12'h800;
  localparam logic [11:0] CTRL_OFFSET   = 12'h804;

  localparam int STAT_IN_COUNT_LSB  = 0;
  localparam int STAT_OUT_COUNT_LSB = 8;
  localparam int STAT_COUNT_BITS    = 5;
  localparam int STAT_OVERFLOW_BIT  = 16;
  localparam int STAT_UNDERFLOW_BIT = 17;
  localparam int STAT_BUSY_BIT      = 18;
  localparam int CTRL_FLUSH_BIT     = 0;

  typedef enum logic [1:0] {
    ENG_IDLE = 2'd0,
    ENG_LOAD = 2'd1,
    ENG_EMIT = 2'd2
  } eng_state_t;

  typedef enum logic [2:0] {
    RGN_NONE   = 3'd0,
    RGN_PUSH   = 3'd1,
    RGN_POP    = 3'd2,
    RGN_STATUS = 3'd3,
    RGN_CTRL   = 3'd4
  } region_t;

  // Word-granular decode of the 4 KB window; byte offset bits are ignored.
  function automatic region_t decode_region(input logic [11:0] addr);
    logic [11:0] word;
    word = {addr[11:2], 2'b00};
    if (word[11:10] == PUSH_BASE[11:10]) return RGN_PUSH;
    if (word[11:10] == POP_BASE[11:10])  return RGN_POP;
    if (word == STATUS_OFFSET)           return RGN_STATUS;
    if (word == CTRL_OFFSET)             return RGN_CTRL;
    return RGN_NONE;
  endfunction

endpackage

// File: rtl/accel_sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers so full and empty are distinct.
// Push is ignored when full, pop when empty; flush empties it synchronously.
module accel_sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign count    = wr_ptr - rd_ptr;
  assign full     = (count == FULL_COUNT);
  assign empty    = (wr_ptr == rd_ptr);
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/accel_ahb_fifo_wrapper.sv
// AHB-Lite slave feeding an input FIFO through a transfer engine into an output FIFO.
// Define ACCEL_WRAP_ERR_RESP_EN to answer push-to-full / pop-from-empty with an AHB ERROR.
module accel_ahb_fifo_wrapper
  import accel_wrap_pkg::*;
#(
  parameter int ADDRWIDTH   = 12,
  parameter int FIFO_DEPTH  = 16,
  parameter int BLOCK_WORDS = 8
) (
  input  logic                 HCLK,
  input  logic                 HRESETn,
  input  logic                 HSELS,
  input  logic                 HREADYS,
  input  logic                 HWRITES,
  input  logic [ADDRWIDTH-1:0] HADDRS,
  input  logic [1:0]           HTRANSS,
  input  logic [2:0]           HSIZES,
  input  logic [3:0]           HPROTS,
  input  logic [31:0]          HWDATAS,
  output logic                 HREADYOUTS,
  output logic                 HRESPS,
  output logic [31:0]          HRDATAS,
  output logic                 ip_data_req,
  output logic                 op_data_req
);

  localparam int CW        = $clog2(FIFO_DEPTH) + 1;
  localparam int ROOM_INT  = FIFO_DEPTH - 1;
  localparam logic [CW-1:0] ROOM_LIMIT = ROOM_INT[CW-1:0];

  logic        dp_valid;
  logic        dp_write;
  logic [11:0] dp_addr;
  region_t     dp_rgn;

  logic wr_push, rd_pop, st_rd, ctrl_wr, flush;
  logic bad_push, bad_pop, quiet;
  logic ovf_sticky, unf_sticky;

  logic          in_push, in_pop, in_full, in_empty;
  logic          out_push, out_pop, out_full, out_empty;
  logic [31:0]   in_head, out_head;
  logic [CW-1:0] in_count, out_count;

  eng_state_t  eng_state;
  logic [31:0] hold;
  logic [31:0] status;

  // Size and protection are don't-care; address bits above the window are ignored.
  logic unused_ok;
  assign unused_ok = ^{HSIZES, HPROTS, HADDRS};

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dp_valid <= 1'b0;
      dp_write <= 1'b0;
      dp_addr  <= '0;
    end else if (HREADYS) begin
      dp_valid <= HSELS & HTRANSS[1];
      dp_write <= HWRITES;
      dp_addr  <= HADDRS[11:0];
    end
  end

  assign dp_rgn   = decode_region(dp_addr);
  assign wr_push  = dp_valid &  dp_write & (dp_rgn == RGN_PUSH);
  assign rd_pop   = dp_valid & ~dp_write & (dp_rgn == RGN_POP);
  assign st_rd    = dp_valid & ~dp_write & (dp_rgn == RGN_STATUS);
  assign ctrl_wr  = dp_valid &  dp_write & (dp_rgn == RGN_CTRL);
  assign flush    = ctrl_wr & HWDATAS[CTRL_FLUSH_BIT];
  assign bad_push = wr_push & in_full;
  assign bad_pop  = rd_pop & out_empty;

`ifdef ACCEL_WRAP_ERR_RESP_EN
  // Cycle 1 of ERROR holds the bus; cycle 2 (quiet) must not touch the FIFOs.
  logic err_first;
  logic err_second;
  assign err_first = (bad_push | bad_pop) & ~err_second;
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) err_second <= 1'b0;
    else          err_second <= err_first;
  end
  assign HREADYOUTS = ~err_first;
  assign HRESPS     = err_first | err_second;
  assign quiet      = err_second;
`else
  assign HREADYOUTS = 1'b1;
  assign HRESPS     = 1'b0;
  assign quiet      = 1'b0;
`endif

  assign in_push  = wr_push & ~quiet;
  assign out_pop  = rd_pop & ~quiet;
  assign in_pop   = (eng_state == ENG_LOAD);
  assign out_push = (eng_state == ENG_EMIT) & ~out_full;

  accel_sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(32)) u_in_fifo (
    .clk       (HCLK),
    .rst_n     (HRESETn),
    .flush     (flush),
    .push      (in_push),
    .push_data (HWDATAS),
    .pop       (in_pop),
    .pop_data  (in_head),
    .count     (in_count),
    .full      (in_full),
    .empty     (in_empty)
  );

  accel_sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(32)) u_out_fifo (
    .clk       (HCLK),
    .rst_n     (HRESETn),
    .flush     (flush),
    .push      (out_push),
    .push_data (hold),
    .pop       (out_pop),
    .pop_data  (out_head),
    .count     (out_count),
    .full      (out_full),
    .empty     (out_empty)
  );

  // Engine only starts a word when the output can take it, so a held word never stalls.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      eng_state <= ENG_IDLE;
      hold      <= '0;
    end else if (flush) begin
      eng_state <= ENG_IDLE;
      hold      <= '0;
    end else begin
      case (eng_state)
        ENG_IDLE: if (!in_empty && !out_full) eng_state <= ENG_LOAD;
        ENG_LOAD: begin
          hold      <= in_head;
          eng_state <= ENG_EMIT;
        end
        ENG_EMIT: begin
          if (!out_full) begin
            if (!in_empty && (out_count < ROOM_LIMIT)) eng_state <= ENG_LOAD;
            else                                       eng_state <= ENG_IDLE;
          end
        end
        default: eng_state <= ENG_IDLE;
      endcase
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      ovf_sticky <= 1'b0;
      unf_sticky <= 1'b0;
    end else if (flush) begin
      ovf_sticky <= 1'b0;
      unf_sticky <= 1'b0;
    end else begin
      if (bad_push && !quiet) ovf_sticky <= 1'b1;
      if (bad_pop && !quiet)  unf_sticky <= 1'b1;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      ip_data_req <= 1'b0;
      op_data_req <= 1'b0;
    end else begin
      ip_data_req <= (FIFO_DEPTH - int'(in_count)) >= BLOCK_WORDS;
      op_data_req <= int'(out_count) >= BLOCK_WORDS;
    end
  end

  always_comb begin
    status = '0;
    status[STAT_IN_COUNT_LSB +: STAT_COUNT_BITS]  = STAT_COUNT_BITS'(in_count);
    status[STAT_OUT_COUNT_LSB +: STAT_COUNT_BITS] = STAT_COUNT_BITS'(out_count);
    status[STAT_OVERFLOW_BIT]  = ovf_sticky;
    status[STAT_UNDERFLOW_BIT] = unf_sticky;
    status[STAT_BUSY_BIT]      = (eng_state != ENG_IDLE);
  end

  always_comb begin
    HRDATAS = '0;
    if (rd_pop && !out_empty) HRDATAS = out_head;
    else if (st_rd)           HRDATAS = status;
  end

endmodule
